axi2ahb_cmd_arb: RTL
====================

// Module: axi2ahb_cmd_arb
// PURPOSE
//  AXI slave address front-end of the AXI-to-AHB bridge. It sits directly upstream of the AHB control FSM.
//  - Accepts one AW or AR request at a time, with round-robin arbitration between the two channels.
//  - Latches the request as a stable command and holds it until the controller pulses completion.
//  - For writes, it then returns the B response. W and R data paths are handled outside this block.
// PARAMETERS
//  AXI_ADDR_WIDTH  8  width of AxADDR and cmd_start_addr_o
//  AXI_ID_WIDTH    4  width of AWID/ARID/BID; the ID of the accepted write is echoed on BID
// PORTS
//  ACLK                clock; all logic on its rising edge
//  ARESETN             in   1   synchronous, active-low reset
//  AWID                in   AXI_ID_WIDTH    write request ID
//  AWADDR              in   AXI_ADDR_WIDTH  write start address
//  AWLEN               in   8               write burst length minus 1
//  AWBURST             in   2               write burst type
//  AWVALID             in   1               write request valid
//  AWREADY             out  1               write request accepted
//  ARID                in   AXI_ID_WIDTH    read request ID
//  ARADDR              in   AXI_ADDR_WIDTH  read start address
//  ARLEN               in   8               read burst length minus 1
//  ARBURST             in   2               read burst type
//  ARVALID             in   1               read request valid
//  ARREADY             out  1               read request accepted
//  BID                 out  AXI_ID_WIDTH    write response ID
//  BRESP               out  2               write response code
//  BVALID              out  1               write response valid
//  BREADY              in   1               write response accepted
//  cmd_read_o          out  1               current command is a read; stable for the whole command
//  cmd_write_o         out  1               current command is a write; stable for the whole command
//  cmd_start_addr_o    out  AXI_ADDR_WIDTH  AxADDR with bits [1:0] forced to 0
//  cmd_transfer_len_o  out  8               AxLEN
//  cmd_burst_type_o    out  2               AxBURST, possibly remapped (see CONFIGURATION)
//  ctrl_cmd_valid_o    out  1               command available to the controller
//  ctrl_cmd_ready_i    in   1               one-cycle completion pulse from the controller
// BEHAVIOUR
//  Reset (ARESETN=0 at a clock edge)
//  - All outputs are 0: AWREADY, ARREADY, BVALID, BID, BRESP, all cmd_*, ctrl_cmd_valid_o.
//  - State returns to IDLE and the arbitration pointer selects write first.
//  - A reset in mid-command aborts it silently. No B response is sent for an aborted write.
//  States: IDLE, RD_CMD, WR_CMD, WR_RESP.
//  IDLE
//  - AWREADY = IDLE & AWVALID & grant_w. ARREADY = IDLE & ARVALID & ~grant_w. Both are combinational; at most one is high.
//  - grant_w = AWVALID & (~ARVALID | ~last_was_write). last_was_write updates on every accept.
//    If both channels are valid, they alternate. If only one is valid, it is taken immediately.
//  - On accept: latch the cmd_* fields, ID and error flag. Set cmd_read_o xor cmd_write_o.
//    Set ctrl_cmd_valid_o=1 next cycle. Go to RD_CMD or WR_CMD.
//  - Latency from AxVALID to ctrl_cmd_valid_o is 1 cycle.
//  RD_CMD / WR_CMD
//  - Hold all cmd_* outputs constant. Accept no new AW/AR request.
//  - On the edge where ctrl_cmd_ready_i=1: ctrl_cmd_valid_o drops to 0.
//  - RD_CMD then goes to IDLE. WR_CMD goes to WR_RESP with BVALID=1.
//  - cmd_read_o/cmd_write_o clear when leaving RD_CMD/WR_RESP. Valid is therefore never high for a command the controller has already finished.
//  - ctrl_cmd_ready_i high in IDLE or WR_RESP is ignored.
//  WR_RESP
//  - BVALID stays high with BID and BRESP stable until BREADY.
//  - On BVALID&BREADY: go to IDLE. Next accept is possible in the following cycle.
//  - BREADY high before BVALID is ignored. No response is ever skipped or duplicated.
//  - Sustained throughput: one read command every 2 cycles plus the controller time.
// CONFIGURATION
//  Macro AXI2AHB_CMD_CHECK_EN
//  - Defined: a request is illegal if AxBURST==2'b11, or if AxBURST==WRAP with AxLEN not in {3,7,15}.
//    An illegal request is forwarded with cmd_burst_type_o=INCR (2'b01).
//    For an illegal write, BRESP=SLVERR (2'b10); legal writes return OKAY.
//    Reads carry no error indication from this block.
//  - Undefined: no check. Fields are forwarded unchanged and BRESP is always OKAY (2'b00).
// STRUCTURE
//  Package axi2ahb_pkg
//  - BURST_FIXED/INCR/WRAP/RSVD encodings, RESP_OKAY/SLVERR, cmd_state_t (IDLE/RD_CMD/WR_CMD/WR_RESP).
//  - Function is_legal_burst(burst, len).
//  Sub-module rr_arb2
//  - Two-requester round-robin arbiter: req[1:0], accept strobe, grant[1:0], registered pointer.
//  - Instantiated once; everything else is in this module.
// TESTING
//  - Reset: hold ARESETN=0 for 3 cycles with AWVALID=1.
//    -> All outputs 0. AWREADY=1 in the first cycle after release.
//  - Write: AW addr 0x13, len 3, INCR.
//    -> Next cycle cmd_write_o=1, start_addr=0x10, len=3, valid=1.
//    -> Ready pulse -> BVALID=1, BRESP=OKAY, BID=AWID.
//    -> With BREADY held low 4 cycles, BVALID stays high and no new accept occurs.
//  - Contention: AWVALID and ARVALID both high continuously for 4 commands.
//    -> Accept order W,R,W,R with exactly one B per write.
//  - Wrap: AR WRAP len 7 -> burst_type 2'b10 forwarded.
//    -> With CHECK_EN, AW WRAP len 5 -> burst 2'b01 and BRESP=2'b10.
//    -> Without CHECK_EN, burst 2'b10 and BRESP=2'b00.
//  - Abort: reset asserted while in WR_CMD.
//    -> Valid drops, no BVALID. A fresh AR is accepted after reset.
//  - Spurious: ctrl_cmd_ready_i pulse while IDLE.
//    -> No state change. AWREADY still follows AWVALID.

Source files
------------

// File: rtl/axi2ahb_pkg.sv
// Shared encodings and the burst legality rule for the AXI-to-AHB bridge front-end.
package axi2ahb_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    WR_CMD  = 2'd2,
    WR_RESP = 2'd3
  } cmd_state_t;

  // WRAP bursts must cover 4, 8 or 16 beats; the reserved encoding is never legal.
  function automatic logic is_legal_burst(input logic [1:0] burst, input logic [7:0] len);
    logic legal;
    legal = 1'b1;
    if (burst == BURST_RSVD) begin
      legal = 1'b0;
    end else if (burst == BURST_WRAP) begin
      legal = (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    end
    return legal;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: req[0] is the write channel, req[1] the read channel.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_was_write;

  // Write wins unless the read channel is also waiting and write went last.
  assign grant[0] = req[0] & (~req[1] | ~last_was_write);
  assign grant[1] = req[1] & ~grant[0];

  // NOTE: sequential state uses non-blocking assignments and a reset sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_was_write <= 1'b0;
    end else if (accept) begin
      last_was_write <= grant[0];
    end
  end

endmodule

// File: rtl/axi2ahb_cmd_arb.sv
// AXI AW/AR command front-end: arbitrates, latches one command, returns B for writes.
// Optional burst legality check enabled by defining AXI2AHB_CMD_CHECK_EN.
module axi2ahb_cmd_arb
  import axi2ahb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [AXI_ID_WIDTH-1:0]   AWID,
  input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]                AWLEN,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [AXI_ID_WIDTH-1:0]   ARID,
  input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]                ARLEN,
  input  logic [1:0]                ARBURST,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [AXI_ID_WIDTH-1:0]   BID,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic                      cmd_read_o,
  output logic                      cmd_write_o,
  output logic [AXI_ADDR_WIDTH-1:0] cmd_start_addr_o,
  output logic [7:0]                cmd_transfer_len_o,
  output logic [1:0]                cmd_burst_type_o,
  output logic                      ctrl_cmd_valid_o,
  input  logic                      ctrl_cmd_ready_i
);

  cmd_state_t state, next_state;

  logic [1:0]                grant;
  logic                      idle;
  logic                      accept;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]                sel_len;
  logic [1:0]                sel_burst;
  logic                      sel_legal;

  // Readies are masked during reset so every output reads 0 while ARESETN is low.
  assign idle    = ARESETN & (state == IDLE);
  assign AWREADY = idle & grant[0];
  assign ARREADY = idle & grant[1];
  assign accept  = AWREADY | ARREADY;

  rr_arb2 u_arb (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .req    ({ARVALID, AWVALID}),
    .accept (accept),
    .grant  (grant)
  );

  assign sel_addr  = AWREADY ? AWADDR  : ARADDR;
  assign sel_len   = AWREADY ? AWLEN   : ARLEN;
  assign sel_burst = AWREADY ? AWBURST : ARBURST;

`ifdef AXI2AHB_CMD_CHECK_EN
  assign sel_legal = is_legal_burst(sel_burst, sel_len);
`else
  assign sel_legal = 1'b1;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    next_state       = state;
    ctrl_cmd_valid_o = 1'b0;
    cmd_read_o       = 1'b0;
    cmd_write_o      = 1'b0;
    BVALID           = 1'b0;
    case (state)
      IDLE: begin
        if (AWREADY)      next_state = WR_CMD;
        else if (ARREADY) next_state = RD_CMD;
      end
      RD_CMD: begin
        ctrl_cmd_valid_o = 1'b1;
        cmd_read_o       = 1'b1;
        if (ctrl_cmd_ready_i) next_state = IDLE;
      end
      WR_CMD: begin
        ctrl_cmd_valid_o = 1'b1;
        cmd_write_o      = 1'b1;
        if (ctrl_cmd_ready_i) next_state = WR_RESP;
      end
      WR_RESP: begin
        // The write flag stays up until the response handshake completes.
        cmd_write_o = 1'b1;
        BVALID      = 1'b1;
        if (BREADY) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cmd_start_addr_o   <= '0;
      cmd_transfer_len_o <= '0;
      cmd_burst_type_o   <= '0;
      BID                <= '0;
      BRESP              <= RESP_OKAY;
    end else if (accept) begin
      cmd_start_addr_o   <= {sel_addr[AXI_ADDR_WIDTH-1:2], 2'b00};
      cmd_transfer_len_o <= sel_len;
      cmd_burst_type_o   <= sel_legal ? sel_burst : BURST_INCR;
      if (AWREADY) begin
        BID   <= AWID;
        BRESP <= sel_legal ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule
